// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one UART transmitter from NUM_REQ byte sources.
// Each accepted frame gets a one-cycle tx_start, and a watchdog bounds the wait for tx_done.
module uart_tx_arbiter #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_en,
  input  logic [3:0]                   cfg_d_bits,
  input  logic [5:0]                   cfg_stop_ticks,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_start,
  output logic [DATA_BITS-1:0]         tx_din,
  output logic [3:0]                   tx_d_bits,
  output logic [5:0]                   tx_stop_ticks,
  input  logic                         tx_done,
  output logic                         busy,
  output logic [GW-1:0]                grant_id,
  output logic                         xfer_done,
  output logic                         err_timeout,
  input  logic                         err_clr
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [DATA_BITS-1:0] tx_din_q, tx_din_d;
  logic [3:0]           d_bits_q, d_bits_d;
  logic [5:0]           stop_q, stop_d;
  logic                 tx_start_q, tx_start_d;
  logic                 xfer_done_q, xfer_done_d;
  logic                 err_q, err_d;

  logic                 win_found;
  logic [GW-1:0]        win_idx;
  logic                 accept;
  logic [DATA_BITS-1:0] req_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : gen_unpack
    assign req_arr[g] = req_data[g*DATA_BITS +: DATA_BITS];
  end

  // First valid requester searching upward from the slot after the last grant.
  always_comb begin
    int unsigned   idx;
    logic [GW-1:0] idx_w;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx   = (32'(last_grant_q) + i) % NUM_REQ;
      idx_w = GW'(idx);
      if (!win_found && req_valid[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  // Gated by reset so req_ready is already low during the reset cycle.
  assign accept    = reset && cfg_en && win_found && (state_q == StIdle);
  assign req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    tx_din_d     = tx_din_q;
    d_bits_d     = d_bits_q;
    stop_d       = stop_q;
    tx_start_d   = 1'b0;
    xfer_done_d  = 1'b0;
    err_d        = err_clr ? 1'b0 : err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StLaunch;
          tx_start_d = 1'b1;
          grant_d    = win_idx;
          tx_din_d   = req_arr[win_idx];
          d_bits_d   = ((cfg_d_bits == 4'd0) || (32'(cfg_d_bits) > DATA_BITS)) ?
                       4'(DATA_BITS) : cfg_d_bits;
          stop_d     = (cfg_stop_ticks == 6'd0) ? 6'd16 : cfg_stop_ticks;
        end
      end
      StLaunch: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (tx_done) begin
          xfer_done_d  = 1'b1;
          last_grant_d = grant_q;
          state_d      = StIdle;
        end else if (cnt_q == CntMax) begin
          // A timeout wins over a same-cycle err_clr.
          err_d        = 1'b1;
          last_grant_d = grant_q;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      tx_din_q     <= '0;
      d_bits_q     <= 4'(DATA_BITS);
      stop_q       <= 6'd16;
      tx_start_q   <= 1'b0;
      xfer_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      tx_din_q     <= tx_din_d;
      d_bits_q     <= d_bits_d;
      stop_q       <= stop_d;
      tx_start_q   <= tx_start_d;
      xfer_done_q  <= xfer_done_d;
      err_q        <= err_d;
    end
  end

  assign tx_start      = tx_start_q;
  assign tx_din        = tx_din_q;
  assign tx_d_bits     = d_bits_q;
  assign tx_stop_ticks = stop_q;
  assign grant_id      = grant_q;
  assign xfer_done     = xfer_done_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single frame, fairness, clamping,
// watchdog, mid-transfer reset, enable gating and round-robin wrap.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_en = 1'b0;
  logic [3:0]  cfg_d_bits = 4'd8;
  logic [5:0]  cfg_stop_ticks = 6'd16;
  logic [3:0]  req_valid = 4'b0;
  logic [31:0] req_data = 32'b0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic [3:0]  tx_d_bits;
  logic [5:0]  tx_stop_ticks;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;
  logic        xfer_done;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  int total = 0;
  int bad = 0;

  uart_tx_arbiter #(
    .DATA_BITS(8),
    .NUM_REQ(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_en(cfg_en),
    .cfg_d_bits(cfg_d_bits),
    .cfg_stop_ticks(cfg_stop_ticks),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_din(tx_din),
    .tx_d_bits(tx_d_bits),
    .tx_stop_ticks(tx_stop_ticks),
    .tx_done(tx_done),
    .busy(busy),
    .grant_id(grant_id),
    .xfer_done(xfer_done),
    .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_en = 1'b1; req_valid = 4'b0001;
    tick(2);
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_ready got=%b want=0000", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b want=0", tx_start); end
    total++; if (xfer_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", xfer_done); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_timeout); end
    total++; if (tx_din !== 8'h00) begin bad++; $display("FAIL rst_din got=%h want=00", tx_din); end
    total++; if (tx_d_bits !== 4'd8) begin bad++; $display("FAIL rst_dbits got=%0d want=8", tx_d_bits); end
    total++; if (tx_stop_ticks !== 6'd16) begin bad++; $display("FAIL rst_stop got=%0d want=16", tx_stop_ticks); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_gid got=%0d want=0", grant_id); end
    req_valid = 4'b0; reset = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    req_data = 32'h0000_00A5; req_valid = 4'b0001; cfg_d_bits = 4'd8; cfg_stop_ticks = 6'd16;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    tick(1);
    req_valid = 4'b0;
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b want=1", tx_start); end
    total++; if (tx_din !== 8'hA5) begin bad++; $display("FAIL single_din got=%h want=a5", tx_din); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    tick(1);
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_len got=%b want=0", tx_start); end
    tick(3);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    total++; if (xfer_done !== 1'b1) begin bad++; $display("FAIL single_xdone got=%b want=1", xfer_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy); end
    tick(1);
    total++; if (xfer_done !== 1'b0) begin bad++; $display("FAIL single_xdone_len got=%b want=0", xfer_done); end
  endtask

  task automatic test_fairness();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    req_data = 32'h1312_1110; req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      int c;
      logic [3:0] exp_rdy;
      c = 0;
      while (tx_start !== 1'b1 && c < 40) begin
        tick(1);
        c++;
      end
      total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL fair_start k=%0d got=%b want=1", k, tx_start); end
      total++;
      if (grant_id !== 2'(k % 4)) begin
        bad++; $display("FAIL fair_gid k=%0d got=%0d want=%0d", k, grant_id, k % 4);
      end
      total++;
      if (tx_din !== 8'(8'h10 + k % 4)) begin
        bad++; $display("FAIL fair_din k=%0d got=%h want=%h", k, tx_din, 8'(8'h10 + k % 4));
      end
      tick(20);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      exp_rdy = 4'b0001 << ((k + 1) % 4);
      total++; if (xfer_done !== 1'b1) begin bad++; $display("FAIL fair_xdone k=%0d got=%b want=1", k, xfer_done); end
      // The next requester must be offered in the very cycle after tx_done.
      total++;
      if (req_ready !== exp_rdy) begin
        bad++; $display("FAIL fair_b2b k=%0d got=%b want=%b", k, req_ready, exp_rdy);
      end
      if (k == 5) req_valid = 4'b0;
    end
    tick(1);
  endtask

  task automatic test_clamp();
    logic [3:0] d_in  [3] = '{4'd0, 4'd12, 4'd7};
    logic [5:0] s_in  [3] = '{6'd0, 6'd0, 6'd24};
    logic [3:0] d_exp [3] = '{4'd8, 4'd8, 4'd7};
    logic [5:0] s_exp [3] = '{6'd16, 6'd16, 6'd24};
    for (int k = 0; k < 3; k++) begin
      cfg_d_bits = d_in[k]; cfg_stop_ticks = s_in[k]; req_valid = 4'b0100;
      tick(1);
      req_valid = 4'b0;
      total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL clamp_start k=%0d got=%b want=1", k, tx_start); end
      total++;
      if (tx_d_bits !== d_exp[k]) begin
        bad++; $display("FAIL clamp_dbits k=%0d got=%0d want=%0d", k, tx_d_bits, d_exp[k]);
      end
      total++;
      if (tx_stop_ticks !== s_exp[k]) begin
        bad++; $display("FAIL clamp_stop k=%0d got=%0d want=%0d", k, tx_stop_ticks, s_exp[k]);
      end
      tick(2);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      total++; if (xfer_done !== 1'b1) begin bad++; $display("FAIL clamp_xdone k=%0d got=%b want=1", k, xfer_done); end
    end
    cfg_d_bits = 4'd3; cfg_stop_ticks = 6'd5;
    tick(2);
    total++; if (tx_d_bits !== 4'd7) begin bad++; $display("FAIL hold_dbits got=%0d want=7", tx_d_bits); end
    total++; if (tx_stop_ticks !== 6'd24) begin bad++; $display("FAIL hold_stop got=%0d want=24", tx_stop_ticks); end
    total++; if (tx_din !== 8'h12) begin bad++; $display("FAIL hold_din got=%h want=12", tx_din); end
  endtask

  task automatic test_timeout();
    logic seen;
    seen = 1'b0;
    req_valid = 4'b0001;
    tick(1);
    req_valid = 4'b0;
    tick(1);
    for (int i = 0; i < 63; i++) begin
      tick(1);
      if (xfer_done === 1'b1) seen = 1'b1;
    end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", err_timeout); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy63 got=%b want=1", busy); end
    tick(1);
    if (xfer_done === 1'b1) seen = 1'b1;
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err_timeout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy got=%b want=0", busy); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL to_xdone got=%b want=0", seen); end
    // tx_done outside WAIT is ignored.
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    total++; if (xfer_done !== 1'b0) begin bad++; $display("FAIL idle_txdone got=%b want=0", xfer_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_txdone_busy got=%b want=0", busy); end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_clr got=%b want=0", err_timeout); end
    req_valid = 4'b0001;
    tick(1);
    req_valid = 4'b0;
    tick(1);
    tick(63);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_prec got=%b want=1", err_timeout); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100;
    tick(1);
    req_valid = 4'b0;
    tick(5);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%b want=1", busy); end
    reset = 1'b0; req_valid = 4'b1010;
    tick(1);
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL mid_ready got=%b want=0000", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (xfer_done !== 1'b0) begin bad++; $display("FAIL mid_xdone got=%b want=0", xfer_done); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL mid_err got=%b want=0", err_timeout); end
    total++; if (tx_din !== 8'h00) begin bad++; $display("FAIL mid_din got=%h want=00", tx_din); end
    total++; if (tx_d_bits !== 4'd8) begin bad++; $display("FAIL mid_dbits got=%0d want=8", tx_d_bits); end
    total++; if (tx_stop_ticks !== 6'd16) begin bad++; $display("FAIL mid_stop got=%0d want=16", tx_stop_ticks); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL mid_gid got=%0d want=0", grant_id); end
    reset = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_first got=%b want=0010", req_ready); end
    tick(1);
    req_valid = 4'b0;
    total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL mid_gid1 got=%0d want=1", grant_id); end
    total++; if (tx_din !== 8'h11) begin bad++; $display("FAIL mid_din1 got=%h want=11", tx_din); end
    tick(1);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    total++; if (xfer_done !== 1'b1) begin bad++; $display("FAIL mid_xdone1 got=%b want=1", xfer_done); end
  endtask

  task automatic test_enable();
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL en_ready got=%b want=0010", req_ready); end
    tick(2);
    cfg_en = 1'b0;
    tick(3);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    total++; if (xfer_done !== 1'b1) begin bad++; $display("FAIL en_xdone got=%b want=1", xfer_done); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL en_block got=%b want=0000", req_ready); end
    tick(3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_busy got=%b want=0", busy); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL en_block2 got=%b want=0000", req_ready); end
    cfg_en = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL en_resume got=%b want=0010", req_ready); end
    req_valid = 4'b0;
    #1;
  endtask

  task automatic test_rr_wrap();
    req_valid = 4'b1001;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_r3 got=%b want=1000", req_ready); end
    tick(1);
    req_valid = 4'b0;
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL wrap_gid3 got=%0d want=3", grant_id); end
    total++; if (tx_din !== 8'h13) begin bad++; $display("FAIL wrap_din3 got=%h want=13", tx_din); end
    tick(1);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    total++; if (xfer_done !== 1'b1) begin bad++; $display("FAIL wrap_xdone got=%b want=1", xfer_done); end
    req_valid = 4'b1001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_r0 got=%b want=0001", req_ready); end
    tick(1);
    req_valid = 4'b0;
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL wrap_gid0 got=%0d want=0", grant_id); end
    total++; if (tx_din !== 8'h10) begin bad++; $display("FAIL wrap_din0 got=%h want=10", tx_din); end
    tick(1);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_clamp();
    test_timeout();
    test_reset_mid();
    test_enable();
    test_rr_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
